// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and the
// step-count rule used by both the controller and the iterative datapath.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [3:0] MUL_STEPS = 4'd8;

  // Zero means the op finishes on the accept edge without entering EXEC.
  function automatic logic [3:0] step_count(input logic [2:0] op,
                                            input logic [7:0] shamt,
                                            input logic [2:0] rot);
    logic [3:0] n;
    n = 4'd0;
    case (op)
      OP_MUL:         n = MUL_STEPS;
      OP_LSL, OP_LSR: n = (shamt >= 8'd8) ? 4'd8 : shamt[3:0];
      OP_ROR:         n = {1'b0, rot};
      default:        n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: latches operands on load, then performs one
// shift-add multiply step or one 1-bit shift/rotate per clock.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             last_step
);

  logic [2:0]       op_q;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_step;
  logic [7:0]       shamt;

  assign shamt = 8'(b[SHAMT_W-1:0]);

  always_comb begin
    acc_step = acc;
    case (op_q)
      OP_MUL:  acc_step = mplier[0] ? (acc + mcand) : acc;
      OP_LSL:  acc_step = {acc[WIDTH-2:0], 1'b0};
      OP_LSR:  acc_step = {1'b0, acc[WIDTH-1:1]};
      OP_ROR:  acc_step = {acc[0], acc[WIDTH-1:1]};
      default: acc_step = acc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q   <= OP_FWD;
      cnt    <= 4'd0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      op_q   <= op;
      cnt    <= step_count(op, shamt, b[2:0]);
      acc    <= (op == OP_MUL) ? '0 : a;
      mcand  <= a;
      mplier <= b;
    end else if (cnt != 4'd0) begin
      // Multiplicand shifts left so only the low WIDTH product bits survive.
      cnt    <= cnt - 4'd1;
      acc    <= acc_step;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end
  end

  // Value after the step taken on this edge, so the top can capture it
  // on the same edge that enters FINISH.
  assign result    = acc_step;
  assign last_step = (cnt == 4'd1);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU between the register file read ports and its write port.
// Logic ops finish in one cycle; MUL and shifts iterate one step per clock.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO,
  output logic [1:0]       STATE_DBG
);

  // Handshake: START is a request whose implicit ready is !BUSY; it is
  // taken only on an edge where both hold, never queued. DONE marks RESULT
  // as new for exactly one cycle and can drive the register-file WRITE.

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             go_exec;
  logic [3:0]       n_steps;
  logic [7:0]       shamt;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] iter_res;
  logic             iter_last;

  assign shamt   = 8'(DATA2[SHAMT_W-1:0]);
  assign n_steps = step_count(SELECT, shamt, DATA2[2:0]);
  assign accept  = (state == S_IDLE) && START;
  assign go_exec = (n_steps != 4'd0);

  // Iterative ops with zero steps fall through to the DATA1 default.
  always_comb begin
    single_res = DATA1;
    case (SELECT)
      OP_FWD:  single_res = DATA2;
      OP_ADD:  single_res = DATA1 + DATA2;
      OP_AND:  single_res = DATA1 & DATA2;
      OP_OR:   single_res = DATA1 | DATA2;
      default: single_res = DATA1;
    endcase
  end

  seq_alu_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_iter (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (accept),
    .op        (SELECT),
    .a         (DATA1),
    .b         (DATA2),
    .result    (iter_res),
    .last_step (iter_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (START) state_next = go_exec ? S_EXEC : S_FINISH;
      S_EXEC:   if (iter_last) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RESULT <= '0;
    end else if (accept && !go_exec) begin
      RESULT <= single_res;
    end else if ((state == S_EXEC) && iter_last) begin
      RESULT <= iter_res;
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_FINISH);
  assign ZERO      = (RESULT == '0);
  assign STATE_DBG = state;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, random ops against
// an arithmetic reference model, and hand-built handshake/reset sequences.
module tb_seq_alu;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] SELECT;
  logic       START;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;
  logic       ZERO;
  logic [1:0] STATE_DBG;

  logic [7:0] drv_d1;
  logic [7:0] drv_d2;
  logic       use_rf;
  logic [2:0] rf_a1;
  logic [2:0] rf_a2;
  logic [2:0] rf_dst;
  logic [7:0] rf [8];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  int         lat_q [$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] res;
    int         lat;
  } vec_t;

  vec_t vecs [13];

  // Clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Register-file model: reads feed the ALU, DONE acts as WRITE.
  assign DATA1 = use_rf ? rf[rf_a1] : drv_d1;
  assign DATA2 = use_rf ? rf[rf_a2] : drv_d2;

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'(2 * i + 3);
    end else if (use_rf && DONE) begin
      rf[rf_dst] <= RESULT;
    end
  end

  always @(posedge CLK) if (DONE) done_cnt <= done_cnt + 1;

  seq_alu dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .SELECT    (SELECT),
    .START     (START),
    .RESULT    (RESULT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ZERO      (ZERO),
    .STATE_DBG (STATE_DBG)
  );

  // Reference model: plain arithmetic on the opcode rules.
  function automatic logic [7:0] model_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel);
    int ia, ib, amt, r;
    ia = int'(a);
    ib = int'(b);
    amt = ib % 16;
    r = ib % 8;
    case (sel)
      3'd0: return b;
      3'd1: return 8'((ia + ib) % 256);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return 8'((ia * ib) % 256);
      3'd5: return (amt >= 8) ? 8'd0 : 8'((ia << amt) % 256);
      3'd6: return (amt >= 8) ? 8'd0 : 8'(ia >> amt);
      default: return 8'(((ia >> r) | (ia << (8 - r))) % 256);
    endcase
  endfunction

  function automatic int model_lat(input logic [7:0] b, input logic [2:0] sel);
    int amt;
    amt = int'(b) % 16;
    case (sel)
      3'd4:       return 9;
      3'd5, 3'd6: return ((amt >= 8) ? 8 : amt) + 1;
      3'd7:       return (int'(b) % 8) + 1;
      default:    return 1;
    endcase
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: issues one op from IDLE, scrambles inputs after accept, waits for
  // DONE (bounded) and one more edge back to IDLE. side_bad flags BUSY or
  // RESULT misbehaving while the op is in flight.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        output logic [7:0] res, output int lat, output logic z,
                        output logic side_bad);
    logic [7:0] prev;
    prev = RESULT;
    side_bad = 1'b0;
    drv_d1 = a;
    drv_d2 = b;
    SELECT = sel;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    drv_d1 = 8'($urandom);
    drv_d2 = 8'($urandom);
    SELECT = 3'($urandom);
    lat = 1;
    while (!DONE && lat < 20) begin
      if (!BUSY || RESULT !== prev) side_bad = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
    res = RESULT;
    z = ZERO;
    if (!BUSY) side_bad = 1'b1;
    @(posedge CLK); #1;
    if (BUSY || DONE) side_bad = 1'b1;
  endtask

  task automatic do_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel, input logic [7:0] exp_res, input int exp_lat);
    logic [7:0] res;
    int lat;
    logic z, bad;
    run_op(a, b, sel, res, lat, z, bad);
    check({name, ".result"}, res, exp_res);
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".zero"}, z, exp_res == 8'd0);
    check({name, ".busy_hold"}, bad, 1'b0);
  endtask

  initial begin
    logic [7:0] a, b, e, res;
    logic [2:0] sel;
    int lat, el, d0;
    logic z, bad;

    vecs[0]  = '{8'd82,  8'd75,  OP_ADD, 8'd157,  1};
    vecs[1]  = '{8'd200, 8'd56,  OP_ADD, 8'd0,    1};
    vecs[2]  = '{8'd13,  8'd11,  OP_MUL, 8'd143,  9};
    vecs[3]  = '{8'd20,  8'd20,  OP_MUL, 8'd144,  9};
    vecs[4]  = '{8'h80,  8'd3,   OP_LSR, 8'h10,   4};
    vecs[5]  = '{8'h01,  8'd9,   OP_LSL, 8'h00,   9};
    vecs[6]  = '{8'h81,  8'd1,   OP_ROR, 8'hC0,   2};
    vecs[7]  = '{8'h5A,  8'd0,   OP_LSL, 8'h5A,   1};
    vecs[8]  = '{8'h11,  8'h22,  OP_FWD, 8'h22,   1};
    vecs[9]  = '{8'hF0,  8'h3C,  OP_AND, 8'h30,   1};
    vecs[10] = '{8'hF0,  8'h0F,  OP_OR,  8'hFF,   1};
    vecs[11] = '{8'h01,  8'h0F,  OP_ROR, 8'h02,   8};
    vecs[12] = '{8'hFF,  8'h08,  OP_LSR, 8'h00,   9};

    RESET = 1'b1;
    START = 1'b0;
    use_rf = 1'b0;
    drv_d1 = 8'd0;
    drv_d2 = 8'd0;
    SELECT = 3'd0;
    rf_a1 = 3'd0;
    rf_a2 = 3'd0;
    rf_dst = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.result", RESULT, 8'd0);
    check("reset.busy", BUSY, 1'b0);
    check("reset.done", DONE, 1'b0);
    check("reset.zero", ZERO, 1'b1);
    RESET = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++)
      do_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].res, vecs[i].lat);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      sel = 3'($urandom_range(0, 7));
      exp_q.push_back(model_res(a, b, sel));
      lat_q.push_back(model_lat(b, sel));
      run_op(a, b, sel, res, lat, z, bad);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      check($sformatf("rand%0d.result", i), res, e);
      check($sformatf("rand%0d.latency", i), lat, el);
      check($sformatf("rand%0d.zero", i), z, e == 8'd0);
      check($sformatf("rand%0d.busy_hold", i), bad, 1'b0);
    end

    // START held through a MUL while operands and opcode churn
    d0 = done_cnt;
    drv_d1 = 8'd13;
    drv_d2 = 8'd11;
    SELECT = OP_MUL;
    START = 1'b1;
    @(posedge CLK); #1;
    lat = 1;
    while (!DONE && lat < 20) begin
      drv_d1 = 8'($urandom);
      drv_d2 = 8'($urandom);
      SELECT = 3'($urandom);
      @(posedge CLK); #1;
      lat++;
    end
    check("hold.mul_result", RESULT, 8'd143);
    check("hold.mul_latency", lat, 9);
    drv_d1 = 8'd1;
    drv_d2 = 8'd2;
    SELECT = OP_ADD;
    @(posedge CLK); #1;
    check("hold.idle_busy", BUSY, 1'b0);
    check("hold.one_done", done_cnt - d0, 1);
    @(posedge CLK); #1;
    START = 1'b0;
    check("hold.next_accept_done", DONE, 1'b1);
    check("hold.next_result", RESULT, 8'd3);
    @(posedge CLK); #1;

    // RESET in the middle of a MUL
    drv_d1 = 8'd13;
    drv_d2 = 8'd11;
    SELECT = OP_MUL;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    d0 = done_cnt;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("midreset.result", RESULT, 8'd0);
    check("midreset.busy", BUSY, 1'b0);
    check("midreset.done", DONE, 1'b0);
    check("midreset.zero", ZERO, 1'b1);
    repeat (12) @(posedge CLK);
    #1;
    check("midreset.no_done", done_cnt - d0, 0);

    // RESET and START on the same edge: no accept
    do_vec("pre_rs", 8'd1, 8'd2, OP_ADD, 8'd3, 1);
    drv_d1 = 8'd4;
    drv_d2 = 8'd5;
    SELECT = OP_ADD;
    START = 1'b1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    START = 1'b0;
    check("rst_start.busy", BUSY, 1'b0);
    check("rst_start.result", RESULT, 8'd0);
    @(posedge CLK); #1;
    check("rst_start.no_done", DONE, 1'b0);
    check("rst_start.busy2", BUSY, 1'b0);

    // Register-file write-back: r3 = r1 + r2
    use_rf = 1'b1;
    rf_a1 = 3'd1;
    rf_a2 = 3'd2;
    rf_dst = 3'd3;
    run_op(8'd0, 8'd0, OP_ADD, res, lat, z, bad);
    check("rf.result", res, 8'd12);
    check("rf.r3", rf[3], 8'd12);
    check("rf.r1_kept", rf[1], 8'd5);
    use_rf = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle 8-bit ALU sitting directly downstream of the 8×8 register file: it consumes the two register read ports (OUT1/OUT2) as operands and produces the value written back through the register file's IN port. Single-cycle logic ops complete in one cycle. Multiply and shifts run iteratively, one step per clock. A START/BUSY/DONE handshake lets the control unit sequence the write-back; DONE is sized to drive the register file WRITE strobe directly.

## Interface
Parameters:
- WIDTH, 8, operand/result width; only 8 is required to be supported
- SHAMT_W, 4, width of the shift-amount field taken from DATA2[SHAMT_W-1:0]

Ports:
- CLK  in  1  single clock; all state updates on posedge
- RESET  in  1  synchronous, active-high; sampled on posedge CLK
- DATA1  in  8  operand A (register file OUT1)
- DATA2  in  8  operand B / shift amount (register file OUT2)
- SELECT  in  3  opcode, sampled with START
- START  in  1  request; accepted only when BUSY=0
- RESULT  out  8  registered result; holds last value until the next op completes
- BUSY  out  1  high from the accept edge until the return to IDLE
- DONE  out  1  one-cycle pulse; RESULT is valid and new while DONE=1
- ZERO  out  1  combinational (RESULT == 0)

## Operation
- Opcodes: 000 FWD (DATA2), 001 ADD (mod 256), 010 AND, 011 OR, 100 MUL, 101 LSL, 110 LSR, 111 ROR.
- FSM states: IDLE, EXEC, FINISH. BUSY = (state != IDLE). DONE = (state == FINISH).
- IDLE, START=1 at an edge: latch DATA1, DATA2 and SELECT into internal registers; load the step counter.
  - FWD/ADD/AND/OR: compute into RESULT and go to FINISH.
  - Iterative op with step count N>0: go to EXEC.
  - Iterative op with N=0: RESULT = DATA1 and go to FINISH.
- Step counts:
  - MUL: N=8.
  - LSL/LSR: N = min(DATA2[3:0], 8). An amount of 8 or more yields 0.
  - ROR: N = DATA2[2:0].
- EXEC: one step per edge, counter decrements; go to FINISH on the edge that completes step N.
  - MUL: shift-add on latched operands, keeping only the low 8 bits of the product (overflow silently truncated).
  - Shifts: 1-bit shift per step; LSL/LSR fill with zero, ROR rotates bit0 into bit7.
- FINISH: unconditionally go to IDLE on the next edge. START is ignored in EXEC and FINISH; it is not queued.
- Operands are latched at accept, so DATA1/DATA2/SELECT may change freely while BUSY=1.
- RESET (any state, including mid-EXEC):
  - Next edge: state=IDLE, RESULT=0, counter=0, BUSY=0, DONE=0, ZERO=1.
  - Any in-flight op is discarded with no DONE.
  - RESET has priority over START on the same edge.

## Timing
- Accept edge = edge k (START=1, BUSY=0).
- Single-cycle ops and N=0: DONE=1 during cycle k+1. Latency 1.
- Iterative ops: DONE=1 during cycle k+N+1. MUL is always 9 cycles.
- Earliest next accept is edge k+latency+1, since START is only accepted in IDLE. Back-to-back ADDs therefore issue every 2 cycles.
- RESULT and DONE are registered; there is no combinational path from DATA*/SELECT/START to any output except via ZERO←RESULT.
- RESULT changes only on the edge entering FINISH, or on RESET.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_FWD … OP_ROR)
  - state encoding (S_IDLE, S_EXEC, S_FINISH)
  - MUL step count constant (8)
- Natural sub-module seq_alu_iter: operand/accumulator registers, step counter, MUL and shift datapath. Inputs: load, op, a, b. Outputs: result, last_step.
- The top level holds the FSM, the single-cycle ops and the RESULT register.

## Test plan
- Reset, then ADD 82+75 → DONE in cycle k+1, RESULT=157, ZERO=0. ADD 200+56 → RESULT=0, ZERO=1.
- MUL 13×11 → DONE at k+9, RESULT=143. MUL 20×20 → RESULT=144 (truncated). BUSY high k+1..k+9.
- Shifts:
  - LSR 0x80 by 3 → DONE k+4, 0x10.
  - LSL 0x01 by 9 → DONE k+9, 0x00.
  - ROR 0x81 by 1 → 0xC0.
  - LSL by 0 → DONE k+1, RESULT=DATA1.
- START held high through a MUL with changing DATA/SELECT → exactly one DONE, with the result of the originally latched operands; next accept is the IDLE cycle after DONE.
- RESET asserted at EXEC step 4 of a MUL → next cycle RESULT=0, BUSY=0, no DONE pulse. RESET and START on the same edge → no accept.
- Integration with the register file: DONE drives WRITE, RESULT drives IN, and the destination address is held.
  - ADD r1=5, r2=7 into r3 → r3=12 after the DONE edge.
